// File: rtl/raster_unpacker_pkg.sv
// raster_unpacker_pkg
// Shared types and field positions for the raster unpacker.
//   depth_e   : pixel depth code carried in the mode byte
//   mode_t    : the decoded active mode/colour set held by the pipeline
//   CMD_* / BP_* : bit positions inside cmd_in and bp_2_rast_cmd
//   depth_mask(): low-bit mask covering one pixel field of a given depth
package raster_unpacker_pkg;

  typedef enum logic [1:0] {
    DEPTH_1BPP = 2'd0,
    DEPTH_2BPP = 2'd1,
    DEPTH_4BPP = 2'd2,
    DEPTH_8BPP = 2'd3
  } depth_e;

  // cmd_in layout
  localparam int CMD_X_LSB     = 0;
  localparam int CMD_X_MSB     = 2;
  localparam int CMD_WIN_BIT   = 7;
  localparam int CMD_TFG_LSB   = 8;   // text foreground nibble
  localparam int CMD_TBG_LSB   = 12;  // text background nibble
  localparam int CMD_FONTY_LSB = 16;
  localparam int CMD_FONTY_MSB = 21;

  // bp_2_rast_cmd layout
  localparam int BP_DEPTH_LSB  = 0;
  localparam int BP_DEPTH_MSB  = 1;
  localparam int BP_TEXT_BIT   = 6;
  localparam int BP_BG_LSB     = 8;
  localparam int BP_FG_LSB     = 16;

  // Only the mode bits that affect the output are kept in the pipeline.
  typedef struct packed {
    logic [7:0] fg;
    logic [7:0] bg;
    logic       text;
    depth_e     depth;
  } mode_t;

  localparam mode_t MODE_RESET = '{fg: 8'h00, bg: 8'h00, text: 1'b0, depth: DEPTH_1BPP};

  function automatic logic [7:0] depth_mask(input depth_e depth);
    logic [7:0] mask;
    case (depth)
      DEPTH_1BPP: mask = 8'h01;
      DEPTH_2BPP: mask = 8'h03;
      DEPTH_4BPP: mask = 8'h0F;
      DEPTH_8BPP: mask = 8'hFF;
      default:    mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pixel_field_sel.sv
// pixel_field_sel
// Combinational MSB-first field extractor: picks the pixel field addressed
// by the sub-pixel X position out of a RAM byte, zero-extended to 8 bits.
//   byte_in   : RAM byte holding 8/4/2/1 pixels
//   x_in      : sub-pixel X position; low bits below the field size are ignored
//   depth_in  : pixel depth
//   field_out : selected field, right-aligned
module pixel_field_sel
  import raster_unpacker_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic [2:0] x_in,
  input  depth_e     depth_in,
  output logic [7:0] field_out
);

  // Field select: leftmost pixel sits in the byte's MSBs.
  always_comb begin
    field_out = 8'h00;
    case (depth_in)
      DEPTH_1BPP: field_out = {7'h00, byte_in[3'd7 - x_in]};
      DEPTH_2BPP: begin
        case (x_in[2:1])
          2'd0:    field_out = {6'h00, byte_in[7:6]};
          2'd1:    field_out = {6'h00, byte_in[5:4]};
          2'd2:    field_out = {6'h00, byte_in[3:2]};
          2'd3:    field_out = {6'h00, byte_in[1:0]};
          default: field_out = 8'h00;
        endcase
      end
      DEPTH_4BPP: begin
        if (x_in[2]) begin
          field_out = {4'h0, byte_in[3:0]};
        end else begin
          field_out = {4'h0, byte_in[7:4]};
        end
      end
      DEPTH_8BPP: field_out = byte_in;
      default:    field_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/raster_unpacker.sv
// raster_unpacker
// Turns an addressed RAM byte plus its draw command into a palette index,
// one pixel per pixel-clock period (registers advance when pc_ena_in == 0).
//   clk, reset      : clock, asynchronous active-high reset
//   pc_ena_in       : pixel-clock phase; 0 marks the enabled cycle
//   ram_byte_in     : RAM byte aligned to cmd_in
//   cmd_in          : sub-pixel X, window enable, text colours, font Y
//   bp_2_rast_cmd   : mode byte (depth, text slave), bg colour, fg colour
//   line_start      : start-of-line pulse (used only with line latching)
//   pixel_out       : palette index, 0 outside the window
//   pixel_ena_out   : pixel is inside the window
//   cmd_out         : cmd_in delayed to line up with pixel_out
// PIPE_STAGES selects 2 or 3 enabled-cycle latency; any value other than 3
// builds the 2-stage pipeline.
// Build option RASTER_UNPACKER_LINE_LATCH_EN: when defined, bp_2_rast_cmd is
// latched only on enabled cycles with line_start=1, so register writes made
// mid-line apply from the next line; otherwise it is sampled every pixel.
module raster_unpacker
  import raster_unpacker_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  pc_ena_in,
  input  logic [7:0]  ram_byte_in,
  input  logic [31:0] cmd_in,
  input  logic [23:0] bp_2_rast_cmd,
  input  logic        line_start,
  output logic [7:0]  pixel_out,
  output logic        pixel_ena_out,
  output logic [31:0] cmd_out
);

  logic        adv_s;
  mode_t       bp_mode_s;
  logic [7:0]  byte1_q, byte1_d;
  logic [31:0] cmd1_q, cmd1_d;
  mode_t       mode_q, mode_d;
  logic [7:0]  field_s;
  logic [7:0]  colour_s;
  logic [7:0]  pix2_q, pix2_d;
  logic        ena2_q, ena2_d;
  logic [31:0] cmd2_q, cmd2_d;

  assign adv_s = (pc_ena_in == 4'h0);

  assign bp_mode_s = '{fg:    bp_2_rast_cmd[BP_FG_LSB +: 8],
                       bg:    bp_2_rast_cmd[BP_BG_LSB +: 8],
                       text:  bp_2_rast_cmd[BP_TEXT_BIT],
                       depth: depth_e'(bp_2_rast_cmd[BP_DEPTH_MSB:BP_DEPTH_LSB])};

  // Mode bits that never influence the output are deliberately dropped.
`ifdef RASTER_UNPACKER_LINE_LATCH_EN
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_2_rast_cmd[7], bp_2_rast_cmd[5:2]};
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_2_rast_cmd[7], bp_2_rast_cmd[5:2], line_start};
`endif

  // Stage 1 next state: byte, command and active mode, held between enables.
  always_comb begin
    byte1_d = byte1_q;
    cmd1_d  = cmd1_q;
    mode_d  = mode_q;
    if (adv_s) begin
      byte1_d = ram_byte_in;
      cmd1_d  = cmd_in;
`ifdef RASTER_UNPACKER_LINE_LATCH_EN
      if (line_start) begin
        mode_d = bp_mode_s;
      end else begin
        mode_d = mode_q;
      end
`else
      mode_d = bp_mode_s;
`endif
    end else begin
      byte1_d = byte1_q;
      cmd1_d  = cmd1_q;
      mode_d  = mode_q;
    end
  end

  pixel_field_sel u_field_sel (
    .byte_in   (byte1_q),
    .x_in      (cmd1_q[CMD_X_MSB:CMD_X_LSB]),
    .depth_in  (mode_q.depth),
    .field_out (field_s)
  );

  // Colour resolve: text slave only reinterprets 1bpp; 2/4bpp keep fg's upper bits.
  always_comb begin
    colour_s = 8'h00;
    case (mode_q.depth)
      DEPTH_1BPP: begin
        if (mode_q.text) begin
          colour_s = field_s[0] ? {4'h0, cmd1_q[CMD_TFG_LSB +: 4]}
                                : {4'h0, cmd1_q[CMD_TBG_LSB +: 4]};
        end else begin
          colour_s = field_s[0] ? mode_q.fg : mode_q.bg;
        end
      end
      DEPTH_2BPP, DEPTH_4BPP: colour_s = (mode_q.fg & ~depth_mask(mode_q.depth)) | field_s;
      DEPTH_8BPP: colour_s = field_s;
      default:    colour_s = 8'h00;
    endcase
  end

  // Stage 2 next state: windowed palette index and the command alongside it.
  always_comb begin
    pix2_d = pix2_q;
    ena2_d = ena2_q;
    cmd2_d = cmd2_q;
    if (adv_s) begin
      ena2_d = cmd1_q[CMD_WIN_BIT];
      cmd2_d = cmd1_q;
      if (cmd1_q[CMD_WIN_BIT]) begin
        pix2_d = colour_s;
      end else begin
        pix2_d = 8'h00;
      end
    end else begin
      pix2_d = pix2_q;
      ena2_d = ena2_q;
      cmd2_d = cmd2_q;
    end
  end

  // Stage 1 and stage 2 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte1_q <= 8'h00;
      cmd1_q  <= 32'h0000_0000;
      mode_q  <= MODE_RESET;
      pix2_q  <= 8'h00;
      ena2_q  <= 1'b0;
      cmd2_q  <= 32'h0000_0000;
    end else begin
      byte1_q <= byte1_d;
      cmd1_q  <= cmd1_d;
      mode_q  <= mode_d;
      pix2_q  <= pix2_d;
      ena2_q  <= ena2_d;
      cmd2_q  <= cmd2_d;
    end
  end

  generate
    if (PIPE_STAGES == 3) begin : g_stage3
      logic [7:0]  pix3_q, pix3_d;
      logic        ena3_q, ena3_d;
      logic [31:0] cmd3_q, cmd3_d;

      // Stage 3 next state: plain delay of stage 2.
      always_comb begin
        pix3_d = pix3_q;
        ena3_d = ena3_q;
        cmd3_d = cmd3_q;
        if (adv_s) begin
          pix3_d = pix2_q;
          ena3_d = ena2_q;
          cmd3_d = cmd2_q;
        end else begin
          pix3_d = pix3_q;
          ena3_d = ena3_q;
          cmd3_d = cmd3_q;
        end
      end

      // Stage 3 registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pix3_q <= 8'h00;
          ena3_q <= 1'b0;
          cmd3_q <= 32'h0000_0000;
        end else begin
          pix3_q <= pix3_d;
          ena3_q <= ena3_d;
          cmd3_q <= cmd3_d;
        end
      end

      assign pixel_out     = pix3_q;
      assign pixel_ena_out = ena3_q;
      assign cmd_out       = cmd3_q;
    end else begin : g_stage2_out
      assign pixel_out     = pix2_q;
      assign pixel_ena_out = ena2_q;
      assign cmd_out       = cmd2_q;
    end
  endgenerate

endmodule

// File: tb/tb_raster_unpacker.sv
// tb_raster_unpacker
// Self-checking bench for raster_unpacker. Each pixel period is four clocks
// with pc_ena_in stepping 0..3; inputs are scrambled during the disabled
// phases. A reference model computes each pixel arithmetically from the
// depth/colour rules and a queue provides the pipeline latency.
module tb_raster_unpacker;

  localparam int PIPE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pc_ena_in;
  logic [7:0]  ram_byte_in;
  logic [31:0] cmd_in;
  logic [23:0] bp_2_rast_cmd;
  logic        line_start;
  logic [7:0]  pixel_out;
  logic        pixel_ena_out;
  logic [31:0] cmd_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  raster_unpacker #(.PIPE_STAGES(PIPE)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_ena_in     (pc_ena_in),
    .ram_byte_in   (ram_byte_in),
    .cmd_in        (cmd_in),
    .bp_2_rast_cmd (bp_2_rast_cmd),
    .line_start    (line_start),
    .pixel_out     (pixel_out),
    .pixel_ena_out (pixel_ena_out),
    .cmd_out       (cmd_out)
  );

  // ---------------- reference model ----------------
  logic [23:0] m_mode;
  logic [40:0] m_pipe[$];   // {pixel, ena, cmd} per sample
  logic [40:0] exp_s;       // expected outputs after the latest enabled edge
  logic [40:0] first_s;     // outputs observed just after the enabled edge

  function automatic logic [40:0] ref_pixel(input logic [7:0] b, input logic [31:0] c,
                                            input logic [23:0] m);
    int depth  = int'(m[1:0]);
    int bpp    = 1 << depth;
    int slot   = int'(c[2:0]) >> depth;
    int bv     = int'(b);
    int field  = (bv >> (8 - bpp * (slot + 1))) & ((1 << bpp) - 1);
    int fg     = int'(m[23:16]);
    int bg     = int'(m[15:8]);
    int colour;
    logic [7:0] col8;
    if (bpp == 1) begin
      if (m[6]) colour = (field != 0) ? int'(c[11:8]) : int'(c[15:12]);
      else      colour = (field != 0) ? fg : bg;
    end else if (bpp == 8) begin
      colour = bv;
    end else begin
      colour = (fg & ~((1 << bpp) - 1)) | field;
    end
    col8 = colour[7:0];
    if (!c[7]) return {8'h00, 1'b0, c};
    return {col8, 1'b1, c};
  endfunction

  task automatic model_reset();
    m_mode = 24'h0;
    m_pipe.delete();
    for (int i = 0; i < PIPE - 1; i++) m_pipe.push_back(41'h0);
    exp_s = 41'h0;
  endtask

  task automatic model_sample(input logic [7:0] b, input logic [31:0] c,
                              input logic [23:0] bp, input logic ls);
`ifdef RASTER_UNPACKER_LINE_LATCH_EN
    if (ls) m_mode = bp;
`else
    m_mode = bp;
`endif
    m_pipe.push_back(ref_pixel(b, c, m_mode));
    exp_s = m_pipe.pop_front();
  endtask

  // One pixel period: enabled sample, then three disabled clocks of noise.
  task automatic do_pixel(input logic [7:0] b, input logic [31:0] c,
                          input logic [23:0] bp, input logic ls);
    @(negedge clk);
    pc_ena_in = 4'd0; ram_byte_in = b; cmd_in = c; bp_2_rast_cmd = bp; line_start = ls;
    model_sample(b, c, bp, ls);
    @(posedge clk); #1;
    first_s = {pixel_out, pixel_ena_out, cmd_out};
    for (int p = 1; p < 4; p++) begin
      @(negedge clk);
      pc_ena_in     = 4'(p);
      ram_byte_in   = 8'($urandom);
      cmd_in        = $urandom;
      bp_2_rast_cmd = 24'($urandom);
      line_start    = 1'($urandom);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; pc_ena_in = 4'd0; ram_byte_in = 8'hFF; cmd_in = 32'hFFFF_FFFF;
    bp_2_rast_cmd = 24'hFFFFFF; line_start = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({pixel_out, pixel_ena_out, cmd_out} !== 41'h0)
      $display("FAIL reset_state got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, 41'h0);
    else n_pass++;
    pc_ena_in = 4'd3;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_1bpp_vector();
    logic [7:0] tab [8];
    tab = '{8'h0F, 8'h01, 8'h0F, 8'h01, 8'h01, 8'h0F, 8'h01, 8'h0F};
    for (int i = 0; i <= 8; i++) begin
      do_pixel(8'hA5, 32'h0000_0080 | 32'(i % 8), 24'h0F_01_00, 1'b1);
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s)
        $display("FAIL 1bpp_model got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if (pixel_out !== tab[i-1])
          $display("FAIL 1bpp_vector x=%0d got %h want %h", i - 1, pixel_out, tab[i-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_4bpp();
    logic [7:0] want [3];
    want = '{8'h00, 8'hE3, 8'hEC};
    do_pixel(8'h3C, 32'h0000_0080, 24'hE0_00_02, 1'b1);
    do_pixel(8'h3C, 32'h0000_0084, 24'hE0_00_02, 1'b1);
    n_total++;
    if (pixel_out !== want[1]) $display("FAIL 4bpp_x0 got %h want %h", pixel_out, want[1]);
    else n_pass++;
    do_pixel(8'h3C, 32'h0000_0080, 24'hE0_00_02, 1'b1);
    n_total++;
    if (pixel_out !== want[2]) $display("FAIL 4bpp_x4 got %h want %h", pixel_out, want[2]);
    else n_pass++;
  endtask

  task automatic test_text_slave();
    do_pixel(8'h80, 32'h0000_7280, 24'h00_00_40, 1'b1);
    do_pixel(8'h80, 32'h0000_7281, 24'h00_00_40, 1'b1);
    n_total++;
    if (pixel_out !== 8'h02) $display("FAIL text_x0 got %h want %h", pixel_out, 8'h02);
    else n_pass++;
    do_pixel(8'h80, 32'h0000_7280, 24'h00_00_40, 1'b1);
    n_total++;
    if (pixel_out !== 8'h07) $display("FAIL text_x1 got %h want %h", pixel_out, 8'h07);
    else n_pass++;
  endtask

  task automatic test_window_off();
    for (int i = 0; i < 6; i++) begin
      do_pixel(8'($urandom), $urandom & 32'hFFFF_FF7F, 24'($urandom), 1'b1);
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s)
        $display("FAIL window_off got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if (pixel_out !== 8'h00 || pixel_ena_out !== 1'b0)
          $display("FAIL window_off_blank got %h/%b want 00/0", pixel_out, pixel_ena_out);
        else n_pass++;
      end
    end
  endtask

  task automatic test_depth_change();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
    for (int i = 0; i < 6; i++) begin
      do_pixel(8'h5A, 32'h0000_0080 | 32'(i), {8'hC4, 8'h11, 6'h00, seq[i]}, 1'b1);
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s || first_s !== exp_s)
        $display("FAIL depth_change got %h/%h want %h", first_s,
                 {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_pixel(8'($urandom), $urandom, 24'($urandom), 1'($urandom));
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s)
        $display("FAIL random_model got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
      n_total++;
      if (first_s !== exp_s)
        $display("FAIL random_hold got %h want %h", first_s, exp_s);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_pixel(8'hA7, 32'h0000_0080, 24'h00_00_03, 1'b1);
    do_pixel(8'hA7, 32'h0000_0081, 24'h00_00_03, 1'b1);
    n_total++;
    if (pixel_out !== 8'hA7) $display("FAIL pre_reset got %h want %h", pixel_out, 8'hA7);
    else n_pass++;
    @(negedge clk);
    pc_ena_in = 4'd2;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({pixel_out, pixel_ena_out, cmd_out} !== 41'h0)
      $display("FAIL async_reset got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, 41'h0);
    else n_pass++;
    repeat (2) @(negedge clk);
    pc_ena_in = 4'd3;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      do_pixel(8'hA7, 32'h0000_0080, 24'h00_00_03, 1'b1);
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s)
        $display("FAIL post_reset got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
    end
  endtask

`ifdef RASTER_UNPACKER_LINE_LATCH_EN
  task automatic test_line_latch();
    do_pixel(8'h5A, 32'h0000_0080, 24'h0F_01_00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_pixel(8'h5A, 32'h0000_0080 | 32'(i), 24'h00_00_03, 1'b0);
      n_total++;
      if ({pixel_out, pixel_ena_out, cmd_out} !== exp_s)
        $display("FAIL latch_hold got %h want %h", {pixel_out, pixel_ena_out, cmd_out}, exp_s);
      else n_pass++;
    end
    do_pixel(8'h5A, 32'h0000_0080, 24'h00_00_03, 1'b1);
    do_pixel(8'h5A, 32'h0000_0080, 24'h00_00_03, 1'b0);
    n_total++;
    if (pixel_out !== 8'h5A) $display("FAIL latch_apply got %h want %h", pixel_out, 8'h5A);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_1bpp_vector();
    test_4bpp();
    test_text_slave();
    test_window_off();
    test_depth_change();
    test_random();
    test_reset_mid();
`ifdef RASTER_UNPACKER_LINE_LATCH_EN
    test_line_latch();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/raster_unpacker.md
RASTER_UNPACKER -- requirements
Module: raster_unpacker

Interface
REQ-001 Parameter: PIPE_STAGES, default 2, number of pc_ena-qualified register stages from the inputs to pixel_out; legal values are 2 and 3 only.
REQ-002 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_ena_in  input  4  pixel-clock phase counter; registers advance only when pc_ena_in == 0.
REQ-005 ram_byte_in  input  8  addressed RAM byte, aligned to cmd_in by the upstream address generator.
REQ-006 cmd_in  input  32  fields: [2:0] sub-pixel X position, [7] window enable, [15:8] text colour pair, [21:16] font Y position.
REQ-007 bp_2_rast_cmd  input  24  [7:0] mode byte ([1:0] depth, [6] text slave), [15:8] bg colour, [23:16] fg colour.
REQ-008 line_start  input  1  one-enable-cycle pulse at the start of each raster line.
REQ-009 pixel_out  output  8  palette index.
REQ-010 pixel_ena_out  output  1  pixel_out is opaque (inside the window).
REQ-011 cmd_out  output  32  cmd_in delayed by PIPE_STAGES enabled cycles, for the next layer.

Function
REQ-012 Depth code [1:0] SHALL decode as 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp.
REQ-013 Field extraction SHALL be MSB-first: 1bpp bit (7-x[2:0]); 2bpp bits selected by x[2:1]; 4bpp nibble selected by x[2]; 8bpp whole byte, where x=cmd_in[2:0] and the unused low x bits are ignored.
REQ-014 Colour in bitplane mode: 1bpp field=1 gives fg, field=0 gives bg; 2bpp/4bpp gives {fg upper (8-bpp) bits, field}; 8bpp gives the byte.
REQ-015 Colour in text slave mode (mode[6]=1, 1bpp only): foreground is {4'h0,cmd_in[11:8]} and background is {4'h0,cmd_in[15:12]}; other depths use bitplane rules.
REQ-016 When the window bit is 0: pixel_out=8'h00 and pixel_ena_out=0.
REQ-017 Latency SHALL be exactly PIPE_STAGES enabled cycles from the input sample to pixel_out, pixel_ena_out and cmd_out.
REQ-018 When pc_ena_in != 0, all stages SHALL hold their values; outputs are stable for the whole pixel period.
REQ-019 Stage 1 SHALL register the RAM byte, the command, and the active mode/colour; stage 2 SHALL register the resolved index. The optional stage 3 SHALL be a pure delay.
REQ-020 The active mode/colour set SHALL be selected per REQ-026 and REQ-027.
REQ-021 Depth change mid-stream without the macro: the new depth SHALL take effect on the first enabled sample after the change, with no output glitch within a pixel period.

Reset
REQ-022 While reset is high: pixel_out=0, pixel_ena_out=0, cmd_out=0, all pipeline stages=0, and the active mode register = 24'h0 (1bpp, bg=fg=0).
REQ-023 Reset asserted mid-line SHALL clear the pipeline immediately, asynchronously.
REQ-024 After reset release, the first valid output SHALL appear PIPE_STAGES enabled cycles after the first enabled sample.
REQ-025 With the macro defined, no line latch occurs until the first line_start; until then mode 24'h0 is active.

Configuration
REQ-026 With RASTER_UNPACKER_LINE_LATCH_EN defined: bp_2_rast_cmd SHALL be captured into the active register only on enabled cycles where line_start=1, so mid-line register writes take effect at the next line.
REQ-027 Without RASTER_UNPACKER_LINE_LATCH_EN: bp_2_rast_cmd SHALL be captured on every enabled cycle, and line_start is ignored.

Structure
REQ-028 Package raster_unpacker_pkg SHALL hold the depth enum, the cmd/bp field bit-position constants, and the window/text bit indices.
REQ-029 The combinational field extractor SHALL be the sub-module pixel_field_sel (byte, x, depth in; 8-bit field out).

Verification
REQ-030 1bpp, byte 8'hA5, fg=8'h0F, bg=8'h01, x=0..7 -> pixel_out sequence 0F,01,0F,01,01,0F,01,0F, each 2 enabled cycles later.
REQ-031 4bpp, byte 8'h3C, fg=8'hE0, x=0 then x=4 -> pixel_out E3 then EC.
REQ-032 Text slave, 1bpp, byte 8'h80, cmd_in[15:8]=8'h72, x=0 then x=1 -> pixel_out 02 then 07.
REQ-033 Window bit 0, any byte -> pixel_out=00, pixel_ena_out=0; cmd_out equals cmd_in delayed 2 enabled cycles.
REQ-034 pc_ena_in cycling 0..3, reset pulsed mid-line -> outputs are 0 asynchronously, and data resumes after 2 enabled cycles.
REQ-035 With the macro: depth changed from 1bpp to 8bpp mid-line -> old depth held until line_start, then byte 8'h5A gives pixel_out 5A.
